// File: rtl/rgb_byte_receiver.sv
// Serial R,G,B byte collector with optional per-byte inversion and a one-deep
// output register under valid/ready; sof_i resynchronises to the R byte.
module rgb_byte_receiver #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             sof_i,
  output logic             byte_ready_o,
  output logic [7:0]       r_o,
  output logic [7:0]       g_o,
  output logic [7:0]       b_o,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic             sync_err_o,
  output logic [CNT_W-1:0] pix_cnt_o
);

  typedef enum logic [1:0] {S_R, S_G, S_B} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_hold_r, r_hold_g;
  logic [7:0]       r_r, r_g, r_b;
  logic             r_pix_valid, r_sync_err;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0] w_byte;
  logic       w_accept, w_xfer;
  logic       w_ld_r, w_ld_g, w_ld_out, w_err;

  assign w_byte       = en_i ? (8'hFF - byte_i) : byte_i;
  // Only the B byte can stall: it needs the output register free or draining.
  assign byte_ready_o = (r_state != S_B) || !r_pix_valid || pix_ready_i;
  assign w_accept     = byte_valid_i && byte_ready_o;
  assign w_xfer       = r_pix_valid && pix_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_R;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_r      = 1'b0;
    w_ld_g      = 1'b0;
    w_ld_out    = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      if (sof_i) begin
        w_ld_r      = 1'b1;
        w_state_nxt = S_G;
        w_err       = (r_state != S_R);
      end else begin
        unique case (r_state)
          S_R: begin w_ld_r   = 1'b1; w_state_nxt = S_G; end
          S_G: begin w_ld_g   = 1'b1; w_state_nxt = S_B; end
          S_B: begin w_ld_out = 1'b1; w_state_nxt = S_R; end
          default: w_state_nxt = S_R;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_r    <= '0;
      r_hold_g    <= '0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_pix_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_ld_r) r_hold_r <= w_byte;
      if (w_ld_g) r_hold_g <= w_byte;
      if (w_ld_out) begin
        r_r <= r_hold_r;
        r_g <= r_hold_g;
        r_b <= w_byte;
      end
      r_pix_valid <= w_ld_out || (r_pix_valid && !pix_ready_i);
      r_sync_err  <= w_err;
      if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign r_o         = r_r;
  assign g_o         = r_g;
  assign b_o         = r_b;
  assign pix_valid_o = r_pix_valid;
  assign sync_err_o  = r_sync_err;
  assign pix_cnt_o   = r_cnt;

endmodule

// File: tb/tb_rgb_byte_receiver.sv
// Bench for rgb_byte_receiver: pixel-level reference model checked every cycle,
// plus directed scenarios with hand-computed pixels and counter values.
module tb_rgb_byte_receiver;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             en_i = 1'b0;
  logic [7:0]       byte_i = '0;
  logic             byte_valid_i = 1'b0;
  logic             sof_i = 1'b0;
  logic             byte_ready_o;
  logic [7:0]       r_o, g_o, b_o;
  logic             pix_valid_o;
  logic             pix_ready_i = 1'b1;
  logic             sync_err_o;
  logic [CNT_W-1:0] pix_cnt_o;

  rgb_byte_receiver #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .sof_i(sof_i), .byte_ready_o(byte_ready_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .sync_err_o(sync_err_o), .pix_cnt_o(pix_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes collected so far in the current pixel, the pixel
  // waiting downstream, and the list of pixels handed over.
  int          m_pos, m_cnt;
  logic [7:0]  m_hr, m_hg, m_r, m_g, m_b;
  logic        m_vld, m_err;
  bit          m_init = 0;
  logic [23:0] mdel_q[$];
  logic [23:0] dut_q[$];

  always @(posedge clk) begin : model
    int pos, cnt;
    logic [7:0] hr, hg, r, g, b, cv;
    logic vld, err;
    bit rdy, acc;
    pos = m_pos; cnt = m_cnt; hr = m_hr; hg = m_hg;
    r = m_r; g = m_g; b = m_b; vld = m_vld; err = 1'b0;
    if (rst_i) begin
      pos = 0; cnt = 0; hr = 0; hg = 0; r = 0; g = 0; b = 0; vld = 0;
      m_init <= 1;
    end else begin
      rdy = (pos != 2) || !vld || pix_ready_i;
      acc = byte_valid_i && rdy;
      cv  = en_i ? 8'(255 - int'(byte_i)) : byte_i;
      if (vld && pix_ready_i) begin
        mdel_q.push_back({r, g, b});
        vld = 0;
        cnt = (cnt + 1) % 16;
      end
      if (acc) begin
        if (sof_i) begin err = (pos != 0); hr = cv; pos = 1; end
        else if (pos == 0) begin hr = cv; pos = 1; end
        else if (pos == 1) begin hg = cv; pos = 2; end
        else begin r = hr; g = hg; b = cv; vld = 1; pos = 0; end
      end
    end
    m_pos <= pos; m_cnt <= cnt; m_hr <= hr; m_hg <= hg;
    m_r <= r; m_g <= g; m_b <= b; m_vld <= vld; m_err <= err;
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("byte_ready", 32'(byte_ready_o), 32'((m_pos != 2) || !m_vld || pix_ready_i));
      chk("pix_valid", 32'(pix_valid_o), 32'(m_vld));
      chk("rgb", 32'({r_o, g_o, b_o}), 32'({m_r, m_g, m_b}));
      chk("sync_err", 32'(sync_err_o), 32'(m_err));
      chk("pix_cnt", 32'(pix_cnt_o), 32'(m_cnt));
      if (pix_valid_o && pix_ready_i && !rst_i) dut_q.push_back({r_o, g_o, b_o});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic s, input logic e);
    bit done = 0;
    byte_i = b; sof_i = s; en_i = e; byte_valid_i = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = byte_ready_o;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    byte_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  initial begin
    logic [23:0] exp_del[$];
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_del[$];
    tick(); tick();
    chk("reset_valid", 32'(pix_valid_o), 32'd0);
    chk("reset_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    chk("reset_ready", 32'(byte_ready_o), 32'd1);
    chk("reset_cnt", 32'(pix_cnt_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // plain pixel
    pix_ready_i = 1'b1;
    send(8'h12, 1, 0); send(8'h34, 0, 0); send(8'h56, 0, 0);
    chk("t1_valid", 32'(pix_valid_o), 32'd1);
    chk("t1_rgb", 32'({r_o, g_o, b_o}), 32'h123456);
    tick();
    chk("t1_valid_drop", 32'(pix_valid_o), 32'd0);
    chk("t1_cnt", 32'(pix_cnt_o), 32'd1);
    exp_del.push_back(24'h123456);

    // inverted bytes
    send(8'h00, 1, 1); send(8'h0F, 0, 1); send(8'hFF, 0, 1);
    chk("t2_rgb", 32'({r_o, g_o, b_o}), 32'hFFF000);
    tick();
    chk("t2_cnt", 32'(pix_cnt_o), 32'd2);
    exp_del.push_back(24'hFFF000);

    // backpressure: second B stalls until the first pixel drains
    pix_ready_i = 1'b0;
    send(8'h01, 1, 0); send(8'h02, 0, 0); send(8'h03, 0, 0);
    send(8'h04, 1, 0); send(8'h05, 0, 0);
    byte_i = 8'h06; byte_valid_i = 1'b1;
    tick();
    chk("t3_stall_ready", 32'(byte_ready_o), 32'd0);
    tick();
    chk("t3_held_rgb", 32'({r_o, g_o, b_o}), 32'h010203);
    chk("t3_held_valid", 32'(pix_valid_o), 32'd1);
    pix_ready_i = 1'b1;
    #1;
    chk("t3_ready_release", 32'(byte_ready_o), 32'd1);
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    chk("t3_b2b_rgb", 32'({r_o, g_o, b_o}), 32'h040506);
    chk("t3_b2b_valid", 32'(pix_valid_o), 32'd1);
    chk("t3_cnt_mid", 32'(pix_cnt_o), 32'd3);
    tick();
    chk("t3_cnt", 32'(pix_cnt_o), 32'd4);
    exp_del.push_back(24'h010203); exp_del.push_back(24'h040506);

    // resync mid-pixel
    send(8'h11, 1, 0); send(8'h22, 0, 0); send(8'hAA, 1, 0);
    chk("t4_err", 32'(sync_err_o), 32'd1);
    chk("t4_no_pix", 32'(pix_valid_o), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(sync_err_o), 32'd0);
    send(8'hBB, 0, 0); send(8'hCC, 0, 0);
    chk("t4_rgb", 32'({r_o, g_o, b_o}), 32'hAABBCC);
    tick();
    chk("t4_cnt", 32'(pix_cnt_o), 32'd5);
    exp_del.push_back(24'hAABBCC);

    // counter wrap: 11 more transfers take 5 -> 16 == 0
    for (int k = 0; k < 11; k++) begin
      send(8'(k), 1, 0); send(8'(k + 1), 0, 0); send(8'(k + 2), 0, 0);
      tick();
      exp_del.push_back({8'(k), 8'(k + 1), 8'(k + 2)});
      if (k == 9) chk("t5_cnt15", 32'(pix_cnt_o), 32'd15);
    end
    chk("t5_wrap", 32'(pix_cnt_o), 32'd0);

    // reset with a pixel pending and a partial pixel collected
    pix_ready_i = 1'b0;
    send(8'h31, 1, 0); send(8'h32, 0, 0); send(8'h33, 0, 0);
    send(8'h41, 1, 0); send(8'h42, 0, 0);
    rst_i = 1'b1; byte_i = 8'h55; sof_i = 1'b1; byte_valid_i = 1'b1;
    tick();
    rst_i = 1'b0; byte_valid_i = 1'b0; sof_i = 1'b0;
    chk("t6_valid", 32'(pix_valid_o), 32'd0);
    chk("t6_cnt", 32'(pix_cnt_o), 32'd0);
    chk("t6_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    chk("t6_ready", 32'(byte_ready_o), 32'd1);
    tick();
    chk("t6_no_err", 32'(sync_err_o), 32'd0);
    pix_ready_i = 1'b1;
    send(8'h77, 0, 0); send(8'h88, 0, 0); send(8'h99, 0, 0);
    chk("t6_rgb_fresh", 32'({r_o, g_o, b_o}), 32'h778899);
    tick();
    chk("t6_cnt_fresh", 32'(pix_cnt_o), 32'd1);
    exp_del.push_back(24'h778899);
    tick();

    chk("model_del_count", 32'(mdel_q.size()), 32'(exp_del.size()));
    chk("dut_del_count", 32'(dut_q.size()), 32'(exp_del.size()));
    for (int i = 0; i < exp_del.size(); i++) begin
      if (i < mdel_q.size()) chk("model_del", 32'(mdel_q[i]), 32'(exp_del[i]));
      if (i < dut_q.size())  chk("dut_del", 32'(dut_q[i]), 32'(exp_del[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_byte_receiver.md
RGB_BYTE_RECEIVER -- requirements
Module: rgb_byte_receiver

Interface
REQ-001 Parameter SHALL be: CNT_W, 16, width of the accepted-pixel counter.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk_i  in  1  single clock; all state changes on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  1 = undo 8-bit inversion (255 - x) per byte; sampled when the byte is accepted
- byte_i  in  8  serial colour byte, order R, G, B
- byte_valid_i  in  1  byte_i valid
- sof_i  in  1  marks byte_i as the R byte of a pixel; qualified by byte_valid_i
- byte_ready_o  out  1  receiver can accept byte_i
- r_o, g_o, b_o  out  8 each  assembled pixel
- pix_valid_o  out  1  pixel on r_o/g_o/b_o valid
- pix_ready_i  in  1  downstream accepts pixel
- sync_err_o  out  1  one-cycle pulse: sof_i seen mid-pixel
- pix_cnt_o  out  CNT_W  pixels delivered downstream, wraps

Function
REQ-003 Byte accept SHALL occur in a cycle with byte_valid_i && byte_ready_o; pixel transfer SHALL occur in a cycle with pix_valid_o && pix_ready_i.
REQ-004 Collection FSM SHALL have states S_R, S_G, S_B; an accept SHALL advance S_R->S_G->S_B->S_R; no accept SHALL hold state.
REQ-005 Each accepted byte SHALL be stored as (en_i ? 255 - byte_i : byte_i), 8-bit, no overflow possible.
REQ-006 R and G bytes SHALL go to internal holding registers; they SHALL NOT change r_o/g_o/b_o.
REQ-007 byte_ready_o SHALL be 1 in S_R and S_G; in S_B it SHALL be (!pix_valid_o || pix_ready_i); it SHALL be combinational from state and pix_ready_i, never from byte_valid_i.
REQ-008 Accept of the B byte SHALL load r_o/g_o/b_o from the holding registers and the converted B byte and set pix_valid_o on the next edge; latency from B accept to pix_valid_o = 1 cycle.
REQ-009 pix_valid_o SHALL stay 1, with r_o/g_o/b_o stable, until a transfer; after a transfer with no simultaneous B accept it SHALL drop to 0 on the next edge.
REQ-010 Simultaneous transfer and B accept SHALL reload the output and keep pix_valid_o = 1 (back-to-back pixels, full throughput: 1 pixel per 3 bytes).
REQ-011 An accepted byte with sof_i = 1 SHALL be taken as the R byte from any state; FSM SHALL go to S_G.
REQ-012 If that sof_i byte arrives in S_G or S_B, the partial pixel SHALL be discarded, output register untouched, and sync_err_o SHALL pulse 1 for exactly the next cycle.
REQ-013 sof_i = 1 in S_R SHALL NOT raise sync_err_o; sof_i = 0 in S_R SHALL be accepted as R normally; sof_i without byte_valid_i SHALL be ignored.
REQ-014 pix_cnt_o SHALL increment by 1 on every transfer, modulo 2^CNT_W (all-ones wraps to 0).
REQ-015 en_i MAY change on any byte; each byte SHALL use its own accept-cycle value.

Reset
REQ-016 While rst_i = 1 at an edge: FSM -> S_R; pix_valid_o, sync_err_o, pix_cnt_o, r_o, g_o, b_o and holding registers -> 0.
REQ-017 During and right after reset, byte_ready_o SHALL be 1 (S_R); reset mid-pixel SHALL discard the partial pixel and any undelivered output pixel without sync_err_o.
REQ-018 Bytes presented in a reset cycle SHALL NOT be accepted into state.

Verification
REQ-019 Bench SHALL cover at minimum:
- en_i=0, bytes 0x12,0x34,0x56 (sof on first), pix_ready_i=1 -> next cycle after B: r/g/b=0x12/0x34/0x56, pix_valid_o=1 one cycle, pix_cnt_o=1.
- en_i=1, bytes 0x00,0x0F,0xFF -> r/g/b=0xFF/0xF0/0x00.
- pix_ready_i=0, send two pixels -> first held stable; byte_ready_o=0 in S_B for the second B; raise pix_ready_i -> first transfers, second B accepted same cycle, second pixel appears next cycle, none lost.
- R, G, then sof byte 0xAA -> sync_err_o 1 for one cycle, no pixel output; then 0xBB,0xCC -> pixel AA/BB/CC.
- CNT_W=4, 16 transfers -> pix_cnt_o wraps 15->0.
- rst_i=1 after G byte with a pixel pending -> pix_valid_o=0, pix_cnt_o=0, next 3 bytes form a fresh pixel.
